ad9361_tx_arb: RTL and testbench

AD9361_TX_ARB -- requirements
Module: ad9361_tx_arb

---
 rtl/ad9361_pkg.sv | 17 +
 rtl/ad9361_rr_arb2.sv | 13 +
 rtl/ad9361_tx_arb.sv | 146 ++++++++++++++
 tb/tb_ad9361_tx_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ad9361_pkg.sv
// Shared types for the AD9361 transmit-path arbiter: FSM states and the I/Q sample record.
package ad9361_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] i;
    logic [SAMPLE_W-1:0] q;
  } iq_t;

endpackage

// File: rtl/ad9361_rr_arb2.sv
// Two-way round-robin pick: on contention the requester that was not served last wins.
module ad9361_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) winner = last_served ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ad9361_tx_arb.sv
// Arbitrates two I/Q sample streams onto one 1T1R AD9361 transmit port in bursts.
module ad9361_tx_arb
  import ad9361_pkg::*;
#(
  parameter int MAX_BURST = 4096,
  parameter int IDLE_GAP  = 0
) (
  input  logic                clk_out,
  input  logic                rst,
  input  logic                tx_ce,
  input  logic [SAMPLE_W-1:0] s0_I,
  input  logic [SAMPLE_W-1:0] s0_Q,
  input  logic                s0_valid,
  input  logic                s0_last,
  output logic                s0_ready,
  input  logic [SAMPLE_W-1:0] s1_I,
  input  logic [SAMPLE_W-1:0] s1_Q,
  input  logic                s1_valid,
  input  logic                s1_last,
  output logic                s1_ready,
  output logic [SAMPLE_W-1:0] tx_I,
  output logic [SAMPLE_W-1:0] tx_Q,
  output logic [1:0]          grant,
  output logic                busy,
  output logic                underrun,
  output logic                trunc
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int GAP_W = $clog2(IDLE_GAP + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_served_q, last_served_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [GAP_W-1:0] gap_q, gap_d;
  iq_t              tx_q, tx_d;
  logic             underrun_q, underrun_d;
  logic             trunc_q, trunc_d;
  logic             arm_q;

  logic [1:0] req, winner;
  logic       sel_valid, sel_last;
  iq_t        s0_iq, s1_iq, sel_iq;

  assign req       = {s1_valid, s0_valid};
  assign s0_iq     = '{i: s0_I, q: s0_Q};
  assign s1_iq     = '{i: s1_I, q: s1_Q};
  assign sel_valid = |(grant_q & req);
  assign sel_last  = grant_q[1] ? s1_last : s0_last;
  assign sel_iq    = grant_q[1] ? s1_iq : s0_iq;
  assign cnt_inc   = cnt_q + 1'b1;

  ad9361_rr_arb2 u_rr (
    .req         (req),
    .last_served (last_served_q),
    .winner      (winner)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    tx_d          = tx_q;
    underrun_d    = 1'b0;
    trunc_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_ce) tx_d = '0;
        if (arm_q && (|req)) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (tx_ce) begin
          if (sel_valid) begin
            tx_d  = sel_iq;
            cnt_d = cnt_inc;
            if (sel_last || (cnt_inc == CNT_MAX)) begin
              trunc_d       = !sel_last;
              last_served_d = grant_q[1];
              grant_d       = '0;
              gap_d         = '0;
              state_d       = (IDLE_GAP > 0) ? GAP : IDLE;
            end
          end else begin
            tx_d       = '0;
            underrun_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (tx_ce) begin
          tx_d = '0;
          if (gap_q == GAP_LAST) state_d = IDLE;
          else                   gap_d   = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester 1 starts as "last served" so requester 0 wins the first contention.
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_served_q <= 1'b1;
      cnt_q         <= '0;
      gap_q         <= '0;
      tx_q          <= '0;
      underrun_q    <= 1'b0;
      trunc_q       <= 1'b0;
      arm_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      tx_q          <= tx_d;
      underrun_q    <= underrun_d;
      trunc_q       <= trunc_d;
      arm_q         <= 1'b1;
    end
  end

  assign s0_ready = (state_q == BURST) && grant_q[0] && tx_ce;
  assign s1_ready = (state_q == BURST) && grant_q[1] && tx_ce;
  assign tx_I     = tx_q.i;
  assign tx_Q     = tx_q.q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign underrun = underrun_q;
  assign trunc    = trunc_q;

endmodule

// File: tb/tb_ad9361_tx_arb.sv
// Directed bench: default-parameter arbiter (a) plus a MAX_BURST=4 / IDLE_GAP=2 instance (b).
module tb_ad9361_tx_arb;

  logic        clk_out = 1'b0;
  logic        rst     = 1'b1;
  logic        tx_ce   = 1'b0;
  logic [11:0] s0_I = '0, s0_Q = '0, s1_I = '0, s1_Q = '0;
  logic        s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;

  logic [11:0] a_tx_I, a_tx_Q, b_tx_I, b_tx_Q;
  logic [1:0]  a_grant, b_grant;
  logic        a_busy, a_underrun, a_trunc, a_s0_ready, a_s1_ready;
  logic        b_busy, b_underrun, b_trunc, b_s0_ready, b_s1_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_out = ~clk_out;

  ad9361_tx_arb dut_a (
    .clk_out(clk_out), .rst(rst), .tx_ce(tx_ce),
    .s0_I(s0_I), .s0_Q(s0_Q), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(a_s0_ready),
    .s1_I(s1_I), .s1_Q(s1_Q), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(a_s1_ready),
    .tx_I(a_tx_I), .tx_Q(a_tx_Q), .grant(a_grant), .busy(a_busy),
    .underrun(a_underrun), .trunc(a_trunc)
  );

  ad9361_tx_arb #(.MAX_BURST(4), .IDLE_GAP(2)) dut_b (
    .clk_out(clk_out), .rst(rst), .tx_ce(tx_ce),
    .s0_I(s0_I), .s0_Q(s0_Q), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(b_s0_ready),
    .s1_I(s1_I), .s1_Q(s1_Q), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(b_s1_ready),
    .tx_I(b_tx_I), .tx_Q(b_tx_Q), .grant(b_grant), .busy(b_busy),
    .underrun(b_underrun), .trunc(b_trunc)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive tx_ce for the coming edge, then return 1 time unit after it.
  task automatic cyc(input logic ce);
    tx_ce = ce;
    @(posedge clk_out);
    #1;
  endtask

  // Pulse reset, then spend the one idle edge before a grant is allowed.
  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    cyc(1'b0);
  endtask

  initial begin
    // Reset state and single s0 burst of 3 with tx_ce every second cycle
    cyc(1'b0);
    cyc(1'b0);
    check("rst_grant", 12'(a_grant), 12'd0);
    check("rst_tx_I", a_tx_I, 12'd0);
    check("rst_tx_Q", a_tx_Q, 12'd0);
    check("rst_busy", 12'(a_busy), 12'd0);
    check("rst_underrun", 12'(a_underrun), 12'd0);
    check("rst_trunc", 12'(a_trunc), 12'd0);
    s0_valid = 1'b1; s0_I = 12'd1; s0_Q = 12'hFFF;
    rst = 1'b0;
    cyc(1'b0);
    check("no_grant_first_edge", 12'(a_grant), 12'd0);
    cyc(1'b0);
    check("t1_grant", 12'(a_grant), 12'd1);
    check("t1_busy", 12'(a_busy), 12'd1);
    tx_ce = 1'b1;
    #1;
    check("t1_s0_ready", 12'(a_s0_ready), 12'd1);
    check("t1_s1_ready", 12'(a_s1_ready), 12'd0);
    cyc(1'b1);
    check("t1_tx_I_1", a_tx_I, 12'd1);
    check("t1_tx_Q_1", a_tx_Q, 12'hFFF);
    s0_I = 12'd2;
    cyc(1'b0);
    check("t1_hold", a_tx_I, 12'd1);
    cyc(1'b1);
    check("t1_tx_I_2", a_tx_I, 12'd2);
    s0_I = 12'd3; s0_last = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    check("t1_tx_I_3", a_tx_I, 12'd3);
    check("t1_grant_end", 12'(a_grant), 12'd0);
    s0_valid = 1'b0; s0_last = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    check("t1_tx_I_idle", a_tx_I, 12'd0);
    check("t1_busy_idle", 12'(a_busy), 12'd0);

    // Both requesters always valid, bursts of two: grants alternate from s0
    do_reset();
    s0_valid = 1'b1; s0_I = 12'd10; s0_Q = 12'd0;
    s1_valid = 1'b1; s1_I = 12'd20; s1_Q = 12'd0;
    for (int k = 0; k < 4; k++) begin
      s0_last = 1'b0; s1_last = 1'b0;
      cyc(1'b1);
      check($sformatf("t2_grant_%0d", k), 12'(a_grant), (k % 2 == 0) ? 12'd1 : 12'd2);
      cyc(1'b1);
      s0_last = 1'b1; s1_last = 1'b1;
      cyc(1'b1);
      check($sformatf("t2_end_grant_%0d", k), 12'(a_grant), 12'd0);
      check($sformatf("t2_tx_I_%0d", k), a_tx_I, (k % 2 == 0) ? 12'd10 : 12'd20);
    end

    // s1 burst with one missing sample: underrun pulse, burst continues
    do_reset();
    s0_valid = 1'b0; s0_last = 1'b0;
    s1_valid = 1'b1; s1_last = 1'b0; s1_I = 12'd5;
    cyc(1'b1);
    check("t3_grant", 12'(a_grant), 12'd2);
    check("t3_s0_ready", 12'(a_s0_ready), 12'd0);
    check("t3_s1_ready", 12'(a_s1_ready), 12'd1);
    cyc(1'b1);
    check("t3_tx_I_5", a_tx_I, 12'd5);
    s1_valid = 1'b0; s1_last = 1'b1;
    cyc(1'b1);
    check("t3_tx_I_zero", a_tx_I, 12'd0);
    check("t3_underrun", 12'(a_underrun), 12'd1);
    check("t3_grant_kept", 12'(a_grant), 12'd2);
    s1_valid = 1'b1; s1_last = 1'b0; s1_I = 12'd6;
    cyc(1'b0);
    check("t3_underrun_off", 12'(a_underrun), 12'd0);
    cyc(1'b1);
    check("t3_tx_I_6", a_tx_I, 12'd6);
    s1_I = 12'd7; s1_last = 1'b1;
    cyc(1'b1);
    check("t3_tx_I_7", a_tx_I, 12'd7);
    check("t3_grant_end", 12'(a_grant), 12'd0);

    // MAX_BURST=4 truncation, IDLE_GAP=2 zero strobes, then s1 served
    do_reset();
    s0_valid = 1'b1; s0_last = 1'b0; s0_I = 12'd1;
    s1_valid = 1'b1; s1_last = 1'b1; s1_I = 12'd9;
    cyc(1'b1);
    check("t4_grant_s0", 12'(b_grant), 12'd1);
    for (int k = 1; k <= 4; k++) begin
      s0_I = 12'(k);
      cyc(1'b1);
      check($sformatf("t4_tx_I_%0d", k), b_tx_I, 12'(k));
      check($sformatf("t4_trunc_%0d", k), 12'(b_trunc), (k == 4) ? 12'd1 : 12'd0);
    end
    check("t4_grant_end", 12'(b_grant), 12'd0);
    check("t4_busy_end", 12'(b_busy), 12'd1);
    cyc(1'b1);
    check("t4_gap1_tx", b_tx_I, 12'd0);
    check("t4_gap1_busy", 12'(b_busy), 12'd1);
    check("t4_gap1_trunc", 12'(b_trunc), 12'd0);
    cyc(1'b1);
    check("t4_gap2_tx", b_tx_I, 12'd0);
    check("t4_gap2_busy", 12'(b_busy), 12'd0);
    check("t4_gap2_grant", 12'(b_grant), 12'd0);
    cyc(1'b1);
    check("t4_grant_s1", 12'(b_grant), 12'd2);
    cyc(1'b1);
    check("t4_tx_I_s1", b_tx_I, 12'd9);
    check("t4_s1_no_trunc", 12'(b_trunc), 12'd0);
    check("t4_s1_grant_end", 12'(b_grant), 12'd0);

    // Reset in the middle of a burst after sample 5
    do_reset();
    s0_valid = 1'b1; s0_last = 1'b0;
    s1_valid = 1'b1; s1_last = 1'b0;
    cyc(1'b1);
    for (int k = 1; k <= 5; k++) begin
      s0_I = 12'(k);
      cyc(1'b1);
    end
    check("t5_tx_I_5", a_tx_I, 12'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_tx_I", a_tx_I, 12'd0);
    check("t5_rst_grant", 12'(a_grant), 12'd0);
    check("t5_rst_busy", 12'(a_busy), 12'd0);
    rst = 1'b0;
    cyc(1'b1);
    check("t5_no_grant_first_edge", 12'(a_grant), 12'd0);
    cyc(1'b1);
    check("t5_grant_s0", 12'(a_grant), 12'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
